// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: pc/instr words, prefetch-queue FSM states and
// the {pc, instr} entry carried from memory to fetch.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] pc_t;
  typedef logic [XLEN-1:0] instr_t;

  localparam pc_t PC_INC = pc_t'(4);

  typedef enum logic {
    IPQ_RUN   = 1'b0,
    IPQ_FLUSH = 1'b1
  } ipq_state_e;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/ipq_fifo.sv
// Small synchronous FIFO used by the prefetch queue for fetched entries and for
// the pcs of outstanding memory requests. Head reads as zero when empty.
module ipq_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = fetch_entry_t
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_d    = push_i ? ptr_inc(wr_q) : wr_q;
    rd_d    = pop_i ? ptr_inc(rd_q) : rd_q;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  // flush has priority over any push/pop in the same cycle
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = empty_o ? T'('0) : mem_q[rd_q];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher with redirect flush and in-flight discard.
// Define IPQ_BYPASS_EN to forward a response straight to fetch when the queue is empty.
module instr_prefetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter pc_t         RESET_PC  = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            branch_en_i,
  input  logic [XLEN-1:0] branch_addr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_instr_o
);

  localparam int unsigned QCW = $clog2(DEPTH + 1);
  localparam int unsigned OCW = $clog2(MAX_OUTST + 1);

  ipq_state_e     state_q, state_d;
  pc_t            fetch_pc_q, fetch_pc_d;
  logic [OCW-1:0] discard_q, discard_d;

  fetch_entry_t   q_in, q_head;
  logic           q_push, q_pop, q_full, q_empty;
  logic [QCW-1:0] q_count;

  pc_t            rsp_pc;
  logic           opc_full, opc_empty;
  logic [OCW-1:0] opc_count, outst_nxt;

  logic           req, issue, rsp, drop, byp;

  ipq_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_queue (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (branch_en_i),
    .push_i  (q_push),
    .data_i  (q_in),
    .pop_i   (q_pop),
    .data_o  (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // Tracks issue pcs of every request in flight, including ones later discarded.
  ipq_fifo #(.DEPTH(MAX_OUTST), .T(pc_t)) u_outst_pc (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (1'b0),
    .push_i  (issue),
    .data_i  (fetch_pc_q),
    .pop_i   (rsp),
    .data_o  (rsp_pc),
    .count_o (opc_count),
    .full_o  (opc_full),
    .empty_o (opc_empty)
  );

  assign req   = (state_q == IPQ_RUN) && !branch_en_i && !q_full && !opc_full
               && (32'(q_count) + 32'(opc_count) < DEPTH);
  assign issue = req && imem_gnt_i;
  assign rsp   = imem_rvalid_i && !opc_empty;
  assign drop  = (discard_q != '0);

`ifdef IPQ_BYPASS_EN
  assign byp = q_empty && !drop && rsp && !branch_en_i;
`else
  assign byp = 1'b0;
`endif

  assign q_in   = '{pc: rsp_pc, instr: imem_rdata_i};
  assign q_push = rsp && !drop && !branch_en_i && !(byp && out_ready_i);
  assign q_pop  = !q_empty && out_valid_o && out_ready_i;

  assign outst_nxt = opc_count + OCW'(issue) - OCW'(rsp);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (issue) fetch_pc_d = fetch_pc_q + PC_INC;
    if (rsp && drop) discard_d = discard_q - 1'b1;
    if (state_q == IPQ_FLUSH && discard_d == '0) state_d = IPQ_RUN;
    // everything still in flight after this cycle belongs to the old stream
    if (branch_en_i) begin
      fetch_pc_d = branch_addr_i & ~pc_t'(3);
      discard_d  = outst_nxt;
      state_d    = (outst_nxt != '0) ? IPQ_FLUSH : IPQ_RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IPQ_RUN;
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc_q;
  assign out_valid_o = !branch_en_i && (!q_empty || byp);
  assign out_pc_o    = byp ? rsp_pc : q_head.pc;
  assign out_instr_o = byp ? imem_rdata_i : q_head.instr;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue with an in-order memory model.
module tb_instr_prefetch_queue;
  import riscv_pkg::*;

`ifdef IPQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam pc_t RST_PC = 32'h0;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        branch_en_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_pc_o;
  logic [31:0] out_instr_o;

  instr_prefetch_queue #(.DEPTH(4), .MAX_OUTST(2), .RESET_PC(RST_PC)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .branch_en_i   (branch_en_i),
    .branch_addr_i (branch_addr_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_pc_o      (out_pc_o),
    .out_instr_o   (out_instr_o)
  );

  always #5 clk_i = ~clk_i;

  int           n_checks = 0;
  int           n_fail = 0;
  int           pops = 0;
  fetch_entry_t sb[$];
  fetch_entry_t mon_e;
  pc_t          pend[$];
  logic         resp_en = 1'b0;
  logic         g_l = 1'b0, rv_l = 1'b0, rst_l = 1'b1, ren_l = 1'b0;
  pc_t          a_l = '0;

  function automatic instr_t mem_word(input pc_t a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // expected output stream restarts at every redirect / reset
  task automatic sb_fill(input pc_t start);
    pc_t p;
    sb.delete();
    p = start & ~pc_t'(3);
    for (int i = 0; i < 1024; i++) begin
      sb.push_back('{pc: p, instr: mem_word(p)});
      p = p + pc_t'(4);
    end
  endtask

  // memory: handshake sampled mid-cycle, response presented from the next cycle on
  always @(negedge clk_i) begin
    g_l   = imem_req_o && imem_gnt_i;
    a_l   = imem_addr_o;
    rv_l  = imem_rvalid_i;
    rst_l = reset_i;
    ren_l = resp_en;
  end

  always @(posedge clk_i) begin
    #1;
    if (rst_l) begin
      pend.delete();
    end else begin
      if (rv_l && pend.size() > 0) void'(pend.pop_front());
      if (g_l) pend.push_back(a_l);
    end
    imem_rvalid_i = !rst_l && ren_l && (pend.size() > 0);
    imem_rdata_i  = imem_rvalid_i ? mem_word(pend[0]) : '0;
  end

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (branch_en_i) check_eq("valid_in_branch", 32'(out_valid_o), 32'd0);
      if (out_valid_o && out_ready_i) begin
        if (sb.size() > 0) mon_e = sb.pop_front();
        else mon_e = '{pc: 32'hDEAD_BEEF, instr: 32'hDEAD_BEEF};
        check_eq("out_pc", out_pc_o, mon_e.pc);
        check_eq("out_instr", out_instr_o, mon_e.instr);
        pops++;
      end
      if (imem_req_o) check_eq("addr_align", 32'(imem_addr_o[1:0]), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic redirect(input pc_t t);
    branch_en_i   = 1'b1;
    branch_addr_i = t;
    sb_fill(t);
    step();
    branch_en_i = 1'b0;
  endtask

  task automatic reset_dut(input int n);
    reset_i = 1'b1;
    sb_fill(RST_PC);
    repeat (n) step();
    reset_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int p0;
    step();
    out_ready_i = 1'b1;
    imem_gnt_i  = 1'b1;
    resp_en     = 1'b1;
    reset_dut(2);

    // reset state and first-request latency
    @(negedge clk_i);
    check_eq("rst_valid", 32'(out_valid_o), 32'd0);
    check_eq("rst_out_pc", out_pc_o, 32'd0);
    check_eq("rst_out_instr", out_instr_o, 32'd0);
    check_eq("rst_addr", imem_addr_o, RST_PC);
    check_eq("t1_first_req", 32'(imem_req_o), 32'd1);
    step();
    @(negedge clk_i);
    check_eq("t1_valid_t1", 32'(out_valid_o), 32'(BYP));
    step();
    @(negedge clk_i);
    check_eq("t1_valid_t2", 32'(out_valid_o), 32'd1);
    cnt = 0;
    repeat (20) begin
      step();
      @(negedge clk_i);
      if (out_valid_o) cnt++;
    end
    check_eq("t1_rate", 32'(cnt), 32'd20);

    // back-pressure: queue fills to DEPTH, requests stop
    step();
    out_ready_i = 1'b0;
    repeat (10) step();
    @(negedge clk_i);
    check_eq("t2_full_req", 32'(imem_req_o), 32'd0);
    check_eq("t2_full_valid", 32'(out_valid_o), 32'd1);
    step();
    imem_gnt_i  = 1'b0;
    out_ready_i = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (out_valid_o) cnt++;
      step();
    end
    check_eq("t2_buffered", 32'(cnt), 32'd4);
    @(negedge clk_i);
    check_eq("t2_req_again", 32'(imem_req_o), 32'd1);
    check_eq("t2_hold_addr", imem_addr_o, sb[0].pc);
    step();
    step();
    @(negedge clk_i);
    check_eq("t2_hold_addr2", imem_addr_o, sb[0].pc);
    step();
    imem_gnt_i = 1'b1;
    repeat (8) step();

    // reset while the queue is full
    out_ready_i = 1'b0;
    repeat (10) step();
    reset_dut(1);
    @(negedge clk_i);
    check_eq("t6_valid", 32'(out_valid_o), 32'd0);
    check_eq("t6_addr", imem_addr_o, RST_PC);
    check_eq("t6_out_pc", out_pc_o, 32'd0);
    step();
    out_ready_i = 1'b1;
    repeat (12) step();

    // redirect with two responses in flight
    resp_en = 1'b0;
    repeat (4) step();
    resp_en = 1'b1;
    redirect(32'h103);
    @(negedge clk_i);
    check_eq("t3_flush_req1", 32'(imem_req_o), 32'd0);
    step();
    @(negedge clk_i);
    check_eq("t3_flush_req2", 32'(imem_req_o), 32'd0);
    step();
    @(negedge clk_i);
    check_eq("t3_run_req", 32'(imem_req_o), 32'd1);
    check_eq("t3_run_addr", imem_addr_o, 32'h100);
    repeat (12) step();

    // redirect coinciding with a response, then back-to-back redirects
    repeat (5) step();
    redirect(32'h2000);
    repeat (10) step();
    redirect(32'h3000);
    redirect(32'h4004);
    repeat (10) step();
    resp_en = 1'b0;
    repeat (4) step();
    resp_en = 1'b1;
    redirect(32'h500);
    redirect(32'h600);
    repeat (10) step();

    // address wrap
    redirect(32'hFFFF_FFF8);
    repeat (10) step();

    // randomised traffic
    repeat (400) begin
      out_ready_i = ($urandom_range(3) != 0);
      imem_gnt_i  = ($urandom_range(2) != 0);
      resp_en     = ($urandom_range(3) != 0);
      if ($urandom_range(24) == 0) redirect($urandom());
      else step();
    end
    out_ready_i = 1'b1;
    imem_gnt_i  = 1'b1;
    resp_en     = 1'b1;
    repeat (6) step();
    p0 = pops;
    repeat (30) step();
    check_eq("drain_rate", 32'((pops - p0) >= 25), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
